fault_inject_memory: RTL and testbench
======================================

Name: fault_inject_memory

Overview:
- Memory-side responder for the BIST memory port: accepts we/wraddr/datain writes and re/rdaddr reads, and returns dataout with a valid strobe.
- Carries a small programmable fault table (stuck-at-0, stuck-at-1, rising-transition fault) so the March sequencer's detection of bist_status can be exercised.
- Drop-in replacement for the plain memory model in BIST simulations; also usable stand-alone with faults disabled.

Parameters:
- DWIDTH, 32, data word width.
- AWIDTH, 4, address width; DEPTH = 2**AWIDTH.
- NFAULT, 4, number of fault slots (1..8).
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  write enable.
- wraddr  input  AWIDTH  write address.
- datain  input  DWIDTH  write data.
- re  input  1  read enable.
- rdaddr  input  AWIDTH  read address.
- dataout  output  DWIDTH  read data.
- dout_valid  output  1  one-cycle pulse, dataout carries the result of a read.
- flt_we  input  1  fault-slot program strobe.
- flt_idx  input  3  slot index; only values < NFAULT are used.
- flt_type  input  2  0 = off, 1 = SA0, 2 = SA1, 3 = TF (0->1 transition blocked).
- flt_addr  input  AWIDTH  faulty word address.
- flt_bit  input  5  faulty bit index; only values < DWIDTH are used.
- fault_active  output  1  OR of all slots whose type is not 0.
- fault_hit  output  1  one-cycle pulse, previous cycle's write was altered by a fault.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All DEPTH words cleared to 0; all fault slots set to type 0.
  - dataout = 0, dout_valid = 0, fault_hit = 0, fault_active = 0.
  - Reset asserted mid-read drops the pending read: no dout_valid after rst_n releases.
- Write, on rising edge with we = 1:
  - mem[wraddr] <= F(old, datain).
  - F is applied per bit using every enabled slot whose addr = wraddr:
    - SA0 forces the bit to 0.
    - SA1 forces the bit to 1.
    - TF keeps the bit at 0 when old = 0 and new = 1; the 1->0 transition is unaffected.
  - If several slots hit the same bit, the highest slot index wins.
- fault_hit:
  - Registered; asserts the cycle after a write where F(old, datain) differs from datain.
  - Cleared otherwise.
- Read, on rising edge with re = 1:
  - The word at rdaddr is captured, with SA0/SA1 slots for rdaddr applied as a mask on the read path, so a newly programmed stuck-at is visible without a rewrite.
  - TF is not applied on reads.
- Read latency:
  - RD_LAT = 1: dataout and dout_valid update one edge after re is sampled.
  - RD_LAT = 2: one extra pipeline register is added; reads issue back-to-back with no bubbles.
- Between reads, dataout holds its last value and dout_valid = 0.
- Same-address read and write in the same cycle: read-first (returns the old stored value, masked). The write still commits.
- Fault programming, on rising edge with flt_we = 1:
  - Slot flt_idx <= {flt_type, flt_addr, flt_bit}.
  - The slot takes effect for operations sampled on the following edge.
  - An out-of-range flt_idx or flt_bit is ignored (no slot changes).
  - Setting type 0 disables the slot.
  - flt_we in the same cycle as a write to the same address: the write uses the old slot contents.
- No state machine beyond the read pipeline and the slot registers.
- Address arithmetic is not performed internally; addresses wrap naturally at AWIDTH.

Test Plan:
- No faults, write 0xA5A5A5A5 at addr 3, read addr 3 -> dataout = 0xA5A5A5A5 with dout_valid exactly 1 cycle later (RD_LAT=1), 2 cycles later (RD_LAT=2); fault_hit stays 0.
- Program slot 0 SA1 at addr 5, bit 0; write 0 to addr 5 -> fault_hit pulses; read -> 0x00000001; fault_active = 1.
- Program slot 1 TF at addr 2, bit 31; write 0, then 0xFFFFFFFF -> read 0x7FFFFFFF; write 0 -> read 0.
- Write 0x1 to addr 7, then in one cycle read addr 7 and write 0x2 to addr 7 -> dataout = 0x1; next read -> 0x2.
- Back-to-back reads addr 0..15 with RD_LAT=2 -> 16 consecutive dout_valid pulses, in-order data.
- Assert rst_n low while a read is in flight and after SA0 was programmed -> no dout_valid, all words read 0, fault_active = 0 after reset.

Source files
------------

// File: rtl/fault_inject_memory.sv
// BIST-side memory responder with a small programmable fault table (SA0/SA1/TF).
// Stuck-at faults corrupt both writes and reads; transition faults only block 0->1 writes.
module fault_inject_memory #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 4,
  parameter int NFAULT = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AWIDTH-1:0] wraddr,
  input  logic [DWIDTH-1:0] datain,
  input  logic              re,
  input  logic [AWIDTH-1:0] rdaddr,
  output logic [DWIDTH-1:0] dataout,
  output logic              dout_valid,
  input  logic              flt_we,
  input  logic [2:0]        flt_idx,
  input  logic [1:0]        flt_type,
  input  logic [AWIDTH-1:0] flt_addr,
  input  logic [4:0]        flt_bit,
  output logic              fault_active,
  output logic              fault_hit
);

  localparam int DEPTH = 2 ** AWIDTH;

  typedef enum logic [1:0] {
    FT_OFF = 2'd0,
    FT_SA0 = 2'd1,
    FT_SA1 = 2'd2,
    FT_TF  = 2'd3
  } flt_type_e;

  logic [DWIDTH-1:0] mem_q   [DEPTH];
  flt_type_e         ftype_q [NFAULT];
  logic [AWIDTH-1:0] faddr_q [NFAULT];
  logic [4:0]        fbit_q  [NFAULT];

  logic [DWIDTH-1:0] wold;
  logic [DWIDTH-1:0] wdata_d;
  logic [DWIDTH-1:0] rdata_d;
  logic              fault_hit_q;
  logic              v1_q;
  logic [DWIDTH-1:0] d1_q;

  assign wold = mem_q[wraddr];

  // Slots are scanned in ascending order so the highest matching index wins.
  always_comb begin
    wdata_d = datain;
    for (int unsigned i = 0; i < NFAULT; i++) begin
      if (ftype_q[i] != FT_OFF && faddr_q[i] == wraddr) begin
        for (int unsigned b = 0; b < DWIDTH; b++) begin
          if (32'(fbit_q[i]) == b) begin
            case (ftype_q[i])
              FT_SA0:  wdata_d[b] = 1'b0;
              FT_SA1:  wdata_d[b] = 1'b1;
              FT_TF:   wdata_d[b] = (!wold[b] && datain[b]) ? 1'b0 : datain[b];
              default: wdata_d[b] = datain[b];
            endcase
          end
        end
      end
    end
  end

  always_comb begin
    rdata_d = mem_q[rdaddr];
    for (int unsigned i = 0; i < NFAULT; i++) begin
      if (faddr_q[i] == rdaddr) begin
        for (int unsigned b = 0; b < DWIDTH; b++) begin
          if (32'(fbit_q[i]) == b) begin
            if (ftype_q[i] == FT_SA0) rdata_d[b] = 1'b0;
            if (ftype_q[i] == FT_SA1) rdata_d[b] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    fault_active = 1'b0;
    for (int unsigned i = 0; i < NFAULT; i++) begin
      if (ftype_q[i] != FT_OFF) fault_active = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      fault_hit_q <= 1'b0;
    end else begin
      if (we) mem_q[wraddr] <= wdata_d;
      fault_hit_q <= we && (wdata_d != datain);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NFAULT; i++) begin
        ftype_q[i] <= FT_OFF;
        faddr_q[i] <= '0;
        fbit_q[i]  <= '0;
      end
    end else if (flt_we && 32'(flt_bit) < DWIDTH) begin
      for (int unsigned i = 0; i < NFAULT; i++) begin
        if (32'(flt_idx) == i) begin
          ftype_q[i] <= flt_type_e'(flt_type);
          faddr_q[i] <= flt_addr;
          fbit_q[i]  <= flt_bit;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= re;
      if (re) d1_q <= rdata_d;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              v2_q;
      logic [DWIDTH-1:0] d2_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v2_q <= 1'b0;
          d2_q <= '0;
        end else begin
          v2_q <= v1_q;
          if (v1_q) d2_q <= d1_q;
        end
      end

      assign dataout    = d2_q;
      assign dout_valid = v2_q;
    end else begin : g_lat1
      assign dataout    = d1_q;
      assign dout_valid = v1_q;
    end
  endgenerate

  assign fault_hit = fault_hit_q;

endmodule

// File: tb/tb_fault_inject_memory.sv
// Bench for fault_inject_memory: RD_LAT=1 and RD_LAT=2 instances share stimulus
// and are checked against a word-level reference model of memory and fault slots.
module tb_fault_inject_memory;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NF = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] wraddr = '0;
  logic [DW-1:0] datain = '0;
  logic          re = 1'b0;
  logic [AW-1:0] rdaddr = '0;
  logic          flt_we = 1'b0;
  logic [2:0]    flt_idx = '0;
  logic [1:0]    flt_type = '0;
  logic [AW-1:0] flt_addr = '0;
  logic [4:0]    flt_bit = '0;

  logic [DW-1:0] dout1, dout2;
  logic          dv1, dv2, fa1, fa2, fh1, fh2;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [DW-1:0] mem_m [16];
  logic [1:0]    ty_m  [NF];
  logic [AW-1:0] ad_m  [NF];
  logic [4:0]    bt_m  [NF];
  logic          exp_dv1, exp_dv2, exp_hit;
  logic [DW-1:0] exp_dout1, exp_dout2;

  always #5 clk = ~clk;

  fault_inject_memory #(.DWIDTH(DW), .AWIDTH(AW), .NFAULT(NF), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .we(we), .wraddr(wraddr), .datain(datain),
    .re(re), .rdaddr(rdaddr), .dataout(dout1), .dout_valid(dv1),
    .flt_we(flt_we), .flt_idx(flt_idx), .flt_type(flt_type), .flt_addr(flt_addr),
    .flt_bit(flt_bit), .fault_active(fa1), .fault_hit(fh1)
  );

  fault_inject_memory #(.DWIDTH(DW), .AWIDTH(AW), .NFAULT(NF), .RD_LAT(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .we(we), .wraddr(wraddr), .datain(datain),
    .re(re), .rdaddr(rdaddr), .dataout(dout2), .dout_valid(dv2),
    .flt_we(flt_we), .flt_idx(flt_idx), .flt_type(flt_type), .flt_addr(flt_addr),
    .flt_bit(flt_bit), .fault_active(fa2), .fault_hit(fh2)
  );

  function automatic logic [DW-1:0] model_wr(input logic [AW-1:0] a, input logic [DW-1:0] old,
                                             input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    for (int i = 0; i < NF; i++) begin
      if (ty_m[i] != 2'd0 && ad_m[i] == a) begin
        case (ty_m[i])
          2'd1:    r[bt_m[i]] = 1'b0;
          2'd2:    r[bt_m[i]] = 1'b1;
          default: r[bt_m[i]] = d[bt_m[i]] & old[bt_m[i]];
        endcase
      end
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    r = mem_m[a];
    for (int i = 0; i < NF; i++) begin
      if (ad_m[i] == a && ty_m[i] == 2'd1) r[bt_m[i]] = 1'b0;
      if (ad_m[i] == a && ty_m[i] == 2'd2) r[bt_m[i]] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic model_fa();
    logic r;
    r = 1'b0;
    for (int i = 0; i < NF; i++) if (ty_m[i] != 2'd0) r = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    for (int i = 0; i < NF; i++) begin
      ty_m[i] = '0; ad_m[i] = '0; bt_m[i] = '0;
    end
    exp_dv1 = 1'b0; exp_dv2 = 1'b0; exp_hit = 1'b0;
    exp_dout1 = '0; exp_dout2 = '0;
  endtask

  // Advance the model by the current inputs, then clock the DUTs and settle.
  task automatic tick();
    logic [DW-1:0] nw;
    if (exp_dv1) exp_dout2 = exp_dout1;
    exp_dv2 = exp_dv1;
    exp_dv1 = re;
    if (re) exp_dout1 = model_rd(rdaddr);
    nw = model_wr(wraddr, mem_m[wraddr], datain);
    exp_hit = we && (nw != datain);
    if (we) mem_m[wraddr] = nw;
    if (flt_we && int'(flt_idx) < NF) begin
      ty_m[flt_idx[1:0]] = flt_type;
      ad_m[flt_idx[1:0]] = flt_addr;
      bt_m[flt_idx[1:0]] = flt_bit;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; wraddr = a; datain = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    re = 1'b1; rdaddr = a;
    tick();
    re = 1'b0;
  endtask

  task automatic prog(input logic [2:0] idx, input logic [1:0] ty, input logic [AW-1:0] a,
                      input logic [4:0] b);
    flt_we = 1'b1; flt_idx = idx; flt_type = ty; flt_addr = a; flt_bit = b;
    tick();
    flt_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (dv1 !== 1'b0 || dv2 !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b/%b want 0/0", dv1, dv2); end
    n_cmp++; if (dout1 !== '0 || dout2 !== '0) begin n_bad++; $display("FAIL reset_dout got %h/%h want 0", dout1, dout2); end
    n_cmp++; if (fa1 !== 1'b0 || fh1 !== 1'b0 || fa2 !== 1'b0 || fh2 !== 1'b0) begin n_bad++; $display("FAIL reset_flags got fa=%b fh=%b want 0", fa1, fh1); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    wr(4'd3, 32'hA5A5_A5A5);
    n_cmp++; if (fh1 !== 1'b0 || fh2 !== 1'b0) begin n_bad++; $display("FAIL basic_hit got %b/%b want 0", fh1, fh2); end
    rd(4'd3);
    n_cmp++; if (dv1 !== 1'b1 || dout1 !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL basic_lat1 got v=%b d=%h want 1 a5a5a5a5", dv1, dout1); end
    n_cmp++; if (dv2 !== 1'b0) begin n_bad++; $display("FAIL basic_lat2_early got %b want 0", dv2); end
    tick();
    n_cmp++; if (dv1 !== 1'b0 || dout1 !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL basic_lat1_hold got v=%b d=%h want 0 a5a5a5a5", dv1, dout1); end
    n_cmp++; if (dv2 !== 1'b1 || dout2 !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL basic_lat2 got v=%b d=%h want 1 a5a5a5a5", dv2, dout2); end
    tick();
    n_cmp++; if (dv2 !== 1'b0) begin n_bad++; $display("FAIL basic_lat2_pulse got %b want 0", dv2); end
  endtask

  task automatic test_sa1();
    prog(3'd0, 2'd2, 4'd5, 5'd0);
    n_cmp++; if (fa1 !== 1'b1 || fa2 !== 1'b1) begin n_bad++; $display("FAIL sa1_active got %b/%b want 1", fa1, fa2); end
    wr(4'd5, 32'h0);
    n_cmp++; if (fh1 !== 1'b1 || fh2 !== 1'b1) begin n_bad++; $display("FAIL sa1_hit got %b/%b want 1", fh1, fh2); end
    rd(4'd5);
    n_cmp++; if (fh1 !== 1'b0) begin n_bad++; $display("FAIL sa1_hit_pulse got %b want 0", fh1); end
    n_cmp++; if (dout1 !== 32'h0000_0001) begin n_bad++; $display("FAIL sa1_read got %h want 00000001", dout1); end
    tick();
    n_cmp++; if (dout2 !== 32'h0000_0001) begin n_bad++; $display("FAIL sa1_read_lat2 got %h want 00000001", dout2); end
  endtask

  task automatic test_tf();
    prog(3'd1, 2'd3, 4'd2, 5'd31);
    wr(4'd2, 32'h0);
    wr(4'd2, 32'hFFFF_FFFF);
    n_cmp++; if (fh1 !== 1'b1) begin n_bad++; $display("FAIL tf_hit got %b want 1", fh1); end
    rd(4'd2);
    n_cmp++; if (dout1 !== 32'h7FFF_FFFF) begin n_bad++; $display("FAIL tf_read got %h want 7fffffff", dout1); end
    wr(4'd2, 32'h0);
    n_cmp++; if (fh1 !== 1'b0) begin n_bad++; $display("FAIL tf_fall_hit got %b want 0", fh1); end
    rd(4'd2);
    n_cmp++; if (dout1 !== 32'h0) begin n_bad++; $display("FAIL tf_fall_read got %h want 0", dout1); end
  endtask

  task automatic test_read_first();
    wr(4'd7, 32'h1);
    re = 1'b1; rdaddr = 4'd7; we = 1'b1; wraddr = 4'd7; datain = 32'h2;
    tick();
    re = 1'b0; we = 1'b0;
    n_cmp++; if (dout1 !== 32'h1) begin n_bad++; $display("FAIL rf_old got %h want 00000001", dout1); end
    tick();
    n_cmp++; if (dout2 !== 32'h1) begin n_bad++; $display("FAIL rf_old_lat2 got %h want 00000001", dout2); end
    rd(4'd7);
    n_cmp++; if (dout1 !== 32'h2) begin n_bad++; $display("FAIL rf_new got %h want 00000002", dout1); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    for (int a = 0; a < 16; a++) wr(4'(a), 32'h1000_0000 + 32'(a) * 32'h0101_0101);
    re = 1'b1;
    for (int a = 0; a < 16; a++) begin
      rdaddr = 4'(a);
      tick();
      if (dv2 === 1'b1) pulses++;
      n_cmp++; if (dv1 !== 1'b1 || dout1 !== model_rd(4'(a))) begin n_bad++; $display("FAIL b2b_lat1 a=%0d got v=%b d=%h want 1 %h", a, dv1, dout1, model_rd(4'(a))); end
      if (a > 0) begin
        n_cmp++; if (dv2 !== 1'b1 || dout2 !== model_rd(4'(a - 1))) begin n_bad++; $display("FAIL b2b_lat2 a=%0d got v=%b d=%h want 1 %h", a - 1, dv2, dout2, model_rd(4'(a - 1))); end
      end
    end
    re = 1'b0;
    tick();
    if (dv2 === 1'b1) pulses++;
    n_cmp++; if (dout2 !== model_rd(4'd15)) begin n_bad++; $display("FAIL b2b_last got %h want %h", dout2, model_rd(4'd15)); end
    tick();
    if (dv2 === 1'b1) pulses++;
    n_cmp++; if (pulses != 16) begin n_bad++; $display("FAIL b2b_pulses got %0d want 16", pulses); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      we = 1'($urandom_range(0, 1));
      wraddr = 4'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       datain = 32'h0;
        1:       datain = 32'hFFFF_FFFF;
        default: datain = $urandom;
      endcase
      re = 1'($urandom_range(0, 1));
      rdaddr = 4'($urandom_range(0, 7));
      flt_we = ($urandom_range(0, 7) == 0);
      flt_idx = 3'($urandom_range(0, 7));
      flt_type = 2'($urandom_range(0, 3));
      flt_addr = 4'($urandom_range(0, 7));
      flt_bit = 5'($urandom_range(0, 31));
      tick();
      n_cmp++; if (dv1 !== exp_dv1 || dout1 !== exp_dout1) begin n_bad++; $display("FAIL rnd_lat1 c=%0d got v=%b d=%h want %b %h", c, dv1, dout1, exp_dv1, exp_dout1); end
      n_cmp++; if (dv2 !== exp_dv2 || dout2 !== exp_dout2) begin n_bad++; $display("FAIL rnd_lat2 c=%0d got v=%b d=%h want %b %h", c, dv2, dout2, exp_dv2, exp_dout2); end
      n_cmp++; if (fh1 !== exp_hit || fh2 !== exp_hit) begin n_bad++; $display("FAIL rnd_hit c=%0d got %b/%b want %b", c, fh1, fh2, exp_hit); end
      n_cmp++; if (fa1 !== model_fa() || fa2 !== model_fa()) begin n_bad++; $display("FAIL rnd_active c=%0d got %b/%b want %b", c, fa1, fa2, model_fa()); end
    end
    we = 1'b0; re = 1'b0; flt_we = 1'b0;
  endtask

  task automatic test_reset_inflight();
    wr(4'd4, 32'hFF);
    prog(3'd2, 2'd1, 4'd4, 5'd3);
    n_cmp++; if (fa1 !== 1'b1) begin n_bad++; $display("FAIL rsti_active_pre got %b want 1", fa1); end
    rd(4'd4);
    rst_n = 1'b0;
    model_reset();
    #2;
    n_cmp++; if (dv1 !== 1'b0 || dv2 !== 1'b0 || dout1 !== '0 || dout2 !== '0) begin n_bad++; $display("FAIL rsti_async got v=%b/%b d=%h/%h want 0", dv1, dv2, dout1, dout2); end
    n_cmp++; if (fa1 !== 1'b0 || fa2 !== 1'b0) begin n_bad++; $display("FAIL rsti_active got %b/%b want 0", fa1, fa2); end
    #1;
    rst_n = 1'b1;
    tick();
    n_cmp++; if (dv1 !== 1'b0 || dv2 !== 1'b0) begin n_bad++; $display("FAIL rsti_dropped got %b/%b want 0", dv1, dv2); end
    re = 1'b1;
    for (int a = 0; a < 16; a++) begin
      rdaddr = 4'(a);
      tick();
      n_cmp++; if (dv1 !== 1'b1 || dout1 !== 32'h0) begin n_bad++; $display("FAIL rsti_clear a=%0d got v=%b d=%h want 1 0", a, dv1, dout1); end
    end
    re = 1'b0;
    tick();
    n_cmp++; if (dv2 !== 1'b1 || dout2 !== 32'h0) begin n_bad++; $display("FAIL rsti_clear_lat2 got v=%b d=%h want 1 0", dv2, dout2); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sa1();
    test_tf();
    test_read_first();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
